// File: rtl/fft_uart_sched.sv
// rtl/fft_uart_sched.sv - FFT frame to uart_tx byte scheduler (optional FFT_UART_CHECKSUM_EN)
module fft_uart_sched #(
  parameter int         N_POINTS    = 8,
  parameter int         SAMPLE_W    = 16,
  parameter logic [7:0] HEADER_BYTE = 8'hA5,
  parameter int         GAP_CYCLES  = 2
) (
  input  logic                           i_Clock,
  input  logic                           i_Reset,
  input  logic                           i_Load,
  input  logic [N_POINTS*2*SAMPLE_W-1:0] i_Data,
  input  logic                           i_Tx_Active,
  input  logic                           i_Tx_Done,
  output logic                           o_Tx_DV,
  output logic [7:0]                     o_Tx_Data,
  output logic                           o_Busy,
  output logic                           o_Frame_Done,
  output logic                           o_Overrun
);

  localparam int BPW     = SAMPLE_W / 8;
  localparam int PAYLOAD = N_POINTS * 2 * BPW;
`ifdef FFT_UART_CHECKSUM_EN
  localparam int TOTAL   = PAYLOAD + 2;
`else
  localparam int TOTAL   = PAYLOAD + 1;
`endif
  localparam int IDX_W   = $clog2(TOTAL);
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  logic [1:0]                     state;
  logic [IDX_W-1:0]               idx;
  logic [GAP_W-1:0]               gap_cnt;
  logic [N_POINTS*2*SAMPLE_W-1:0] frame_buf;
  logic [7:0]                     payload [PAYLOAD];
  logic [7:0]                     cur_byte;
  logic                           is_payload;
`ifdef FFT_UART_CHECKSUM_EN
  logic [7:0]                     csum;
`endif

  // Reorder the buffered words into transmit order: word by word, MSB byte first
  always_comb begin
    for (int p = 0; p < PAYLOAD; p++) begin
      payload[p] = frame_buf[SAMPLE_W*(p/BPW) + 8*(BPW-1-(p%BPW)) +: 8];
    end
  end

  // Select the byte addressed by the current index (header, payload, or checksum)
  always_comb begin
    cur_byte   = HEADER_BYTE;
    is_payload = 1'b0;
    for (int p = 0; p < PAYLOAD; p++) begin
      if (idx == IDX_W'(p + 1)) begin
        cur_byte   = payload[p];
        is_payload = 1'b1;
      end
    end
`ifdef FFT_UART_CHECKSUM_EN
    if (idx == LAST_IDX) begin
      cur_byte = csum;
    end
`endif
  end

  // Frame capture, byte sequencing and the uart_tx handshake
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      gap_cnt      <= '0;
      frame_buf    <= '0;
      o_Tx_DV      <= 1'b0;
      o_Tx_Data    <= 8'h00;
      o_Busy       <= 1'b0;
      o_Frame_Done <= 1'b0;
      o_Overrun    <= 1'b0;
    end else begin
      o_Tx_DV      <= 1'b0;
      o_Frame_Done <= 1'b0;
      o_Overrun    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_Load) begin
            frame_buf <= i_Data;
            o_Busy    <= 1'b1;
            idx       <= '0;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // The line may still carry a byte started before a local reset
          if (!i_Tx_Active) begin
            o_Tx_DV   <= 1'b1;
            o_Tx_Data <= cur_byte;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_Tx_Done) begin
            if (idx == LAST_IDX) begin
              state        <= ST_IDLE;
              o_Frame_Done <= 1'b1;
              o_Busy       <= 1'b0;
            end else begin
              idx     <= idx + 1'b1;
              gap_cnt <= GAP_LOAD;
              state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state <= ST_ISSUE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A load while a frame is pending is dropped and flagged
      if (i_Load && o_Busy) begin
        o_Overrun <= 1'b1;
      end
    end
  end

`ifdef FFT_UART_CHECKSUM_EN
  // Running XOR of payload bytes as they are handed to uart_tx
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      csum <= 8'h00;
    end else if (state == ST_IDLE && i_Load) begin
      csum <= 8'h00;
    end else if (state == ST_ISSUE && !i_Tx_Active && is_payload) begin
      csum <= csum ^ cur_byte;
    end
  end
`endif

endmodule

// File: tb/tb_fft_uart_sched.sv
// tb/tb_fft_uart_sched.sv - randomized self-checking bench for fft_uart_sched
module tb_fft_uart_sched;

  localparam int         N_POINTS    = 8;
  localparam int         SAMPLE_W    = 16;
  localparam logic [7:0] HEADER_BYTE = 8'hA5;
  localparam int         GAP_CYCLES  = 2;
  localparam int         FW          = N_POINTS * 2 * SAMPLE_W;
  localparam int         BPW         = SAMPLE_W / 8;
`ifdef FFT_UART_CHECKSUM_EN
  localparam int         TOTAL       = 1 + N_POINTS * 2 * BPW + 1;
`else
  localparam int         TOTAL       = 1 + N_POINTS * 2 * BPW;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load = 1'b0;
  logic [FW-1:0] data = '0;
  logic          tx_active = 1'b0;
  logic          tx_done = 1'b0;
  logic          tx_dv;
  logic [7:0]    tx_data;
  logic          busy;
  logic          frame_done;
  logic          overrun;

  int            checks = 0;
  int            failures = 0;
  logic [7:0]    exp_q[$];
  int            frame_dv_cnt = 0;
  int            ovr_cnt = 0;
  int            fd_cnt = 0;
  int            cyc = 0;
  int            last_done_cyc = 0;
  int            uart_cnt = 0;

  fft_uart_sched #(
    .N_POINTS(N_POINTS), .SAMPLE_W(SAMPLE_W),
    .HEADER_BYTE(HEADER_BYTE), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Load(load), .i_Data(data),
    .i_Tx_Active(tx_active), .i_Tx_Done(tx_done),
    .o_Tx_DV(tx_dv), .o_Tx_Data(tx_data), .o_Busy(busy),
    .o_Frame_Done(frame_done), .o_Overrun(overrun)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: active for a random byte time after DV, then a Done pulse with Active low
  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (tx_active) begin
      if (uart_cnt <= 1) begin
        tx_active <= 1'b0;
        tx_done   <= 1'b1;
      end else begin
        uart_cnt <= uart_cnt - 1;
      end
    end else if (tx_dv) begin
      tx_active <= 1'b1;
      uart_cnt  <= $urandom_range(13, 10);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference stream: header, each word MSB byte first, optional XOR of payload
  task automatic push_expected(input logic [FW-1:0] d);
    logic [SAMPLE_W-1:0] w;
    logic [7:0]          b;
    logic [7:0]          x;
    x = 8'h00;
    exp_q.push_back(HEADER_BYTE);
    for (int k = 0; k < 2 * N_POINTS; k++) begin
      w = d[k*SAMPLE_W +: SAMPLE_W];
      for (int j = BPW - 1; j >= 0; j--) begin
        b = w[j*8 +: 8];
        exp_q.push_back(b);
        x = x ^ b;
      end
    end
`ifdef FFT_UART_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] d;
    for (int k = 0; k < 2 * N_POINTS; k++) begin
      d[k*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'($urandom);
    end
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [FW-1:0] d, input bit accept);
    load = 1'b1;
    data = d;
    if (accept) push_expected(d);
    tick();
    load = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    int n;
    n = 0;
    while (!frame_done && n < 3000) begin
      tick();
      n++;
    end
    check(tag, frame_done, 1'b1);
  endtask

  task automatic wait_dv(input int k, input string tag);
    int n;
    n = 0;
    while (frame_dv_cnt < k && n < 1000) begin
      tick();
      n++;
    end
    check(tag, frame_dv_cnt >= k, 1'b1);
  endtask

  // Output monitor: every DV byte against the reference queue, gap and line-idle rules
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_done) last_done_cyc = cyc;
      if (tx_dv) begin
        check("dv_line_idle", tx_active, 1'b0);
        check("dv_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("dv_byte", tx_data, exp_q.pop_front());
        if (frame_dv_cnt > 0) check("dv_gap", (cyc - last_done_cyc) > GAP_CYCLES, 1'b1);
        frame_dv_cnt++;
      end
      if (overrun) ovr_cnt++;
      if (frame_done) begin
        fd_cnt++;
        check("fd_busy_low", busy, 1'b0);
        check("fd_byte_count", frame_dv_cnt, TOTAL);
        frame_dv_cnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] d;
    int o0;
    int f0;

    // Reset and idle
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_dv", tx_dv, 1'b0);
      check("rst_data", tx_data, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_fd", frame_done, 1'b0);
      check("rst_ovr", overrun, 1'b0);
    end

    // Directed frame: real0=1234, imag0=DEAD
    d = '0;
    d[15:0]  = 16'h1234;
    d[31:16] = 16'hDEAD;
    f0 = fd_cnt;
    do_load(d, 1'b1);
    check("load_busy", busy, 1'b1);
    check("load_no_dv_yet", tx_dv, 1'b0);
    tick();
    check("first_dv", tx_dv, 1'b1);
    check("first_byte", tx_data, HEADER_BYTE);
    wait_fd("frame_a_done");
    check("frame_a_busy_drop", busy, 1'b0);
    tick();
    check("frame_a_fd_once", fd_cnt - f0, 1);
    check("frame_a_drained", exp_q.size(), 0);

    // Overrun during byte 10, then a load in the frame-done cycle
    o0 = ovr_cnt;
    do_load(rand_frame(), 1'b1);
    wait_dv(10, "wait_byte10");
    do_load(rand_frame(), 1'b0);
    check("ovr_pulse", overrun, 1'b1);
    wait_fd("frame_b_done");
    do_load(rand_frame(), 1'b1);
    check("fd_cycle_load_no_ovr", overrun, 1'b0);
    check("fd_cycle_load_busy", busy, 1'b1);
    wait_fd("frame_c_done");
    tick();
    check("ovr_count", ovr_cnt - o0, 1);
    check("frame_c_drained", exp_q.size(), 0);

    // Reset while byte 5 is in flight, then reload while uart_tx is still busy
    do_load(rand_frame(), 1'b1);
    wait_dv(5, "wait_byte5");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    frame_dv_cnt = 0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_dv", tx_dv, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    f0 = fd_cnt;
    do_load(rand_frame(), 1'b1);
    wait_fd("frame_d_done");
    tick();
    check("frame_d_fd_once", fd_cnt - f0, 1);
    check("frame_d_drained", exp_q.size(), 0);

    // A couple more random frames back to back
    for (int r = 0; r < 2; r++) begin
      do_load(rand_frame(), 1'b1);
      wait_fd("frame_rand_done");
      tick();
      check("frame_rand_drained", exp_q.size(), 0);
    end
    check("no_stray_ovr", ovr_cnt - o0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
